// File: rtl/key_debounce.sv
// ---------------------------------------------------------------------------
// key_debounce
//
// Debounces KEYS active-low push buttons. Keys are sampled once per rising
// edge of the slow clk_delay square wave; a level change is accepted only
// after STABLE_TICKS consecutive samples agree on the new level.
//
// Optional feature macro: KEY_RELEASE_PULSE_EN
//   When defined, adds the key_release output (one-clk pulse per accepted
//   release). When undefined, the port and its logic do not exist.
//
// Parameters
//   KEYS          number of buttons (1..8)
//   STABLE_TICKS  consecutive agreeing ticks needed to accept a change (2..255)
//
// Ports
//   clk          system clock, all logic on its rising edge
//   rst          asynchronous active-high reset
//   clk_delay    slow square wave; each rising edge is one sampling tick
//   key_in       raw buttons, active-low (0 = pressed), asynchronous
//   tick         one-clk pulse per rising edge of the synchronized clk_delay
//   key_level    debounced state per key, 1 = pressed
//   key_press    one-clk pulse per accepted press
//   key_release  one-clk pulse per accepted release (KEY_RELEASE_PULSE_EN only)
// ---------------------------------------------------------------------------
module key_debounce #(
  parameter int KEYS         = 4,
  parameter int STABLE_TICKS = 20
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clk_delay,
  input  logic [KEYS-1:0] key_in,
  output logic            tick,
  output logic [KEYS-1:0] key_level,
  output logic [KEYS-1:0] key_press
`ifdef KEY_RELEASE_PULSE_EN
  ,
  output logic [KEYS-1:0] key_release
`endif
);

  localparam int CW = $clog2(STABLE_TICKS + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_TICKS);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    PRESS_WAIT = 2'd1,
    HELD       = 2'd2,
    REL_WAIT   = 2'd3
  } state_t;

  // -------------------------------------------------------------------------
  // clk_delay synchronizer and rising-edge detector
  // -------------------------------------------------------------------------
  logic [1:0] dly_sync_q;
  logic [1:0] fill_q;
  logic       dly_prev_q;

  // fill_q marks when the synchronizer holds real samples rather than reset
  // values. Until then dly_prev_q is pinned to 1, so a clk_delay that is
  // already high when reset releases does not look like a 0->1 edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dly_sync_q <= 2'b00;
      fill_q     <= 2'b00;
      dly_prev_q <= 1'b1;
    end else begin
      dly_sync_q <= {dly_sync_q[0], clk_delay};
      fill_q     <= {fill_q[0], 1'b1};
      dly_prev_q <= fill_q[1] ? dly_sync_q[1] : 1'b1;
    end
  end

  // Both terms are flops, so the pulse is clean and exactly one clk wide.
  assign tick = dly_sync_q[1] & ~dly_prev_q;

  // -------------------------------------------------------------------------
  // Per-key synchronizer and debounce FSM
  // -------------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < KEYS; gi++) begin : g_key
      logic [1:0]    key_sync_q;
      state_t        state_q;
      logic [CW-1:0] cnt_q;
      logic [CW-1:0] cnt_inc;
      logic          pressed;
      logic          level_q;
      logic          press_q;
`ifdef KEY_RELEASE_PULSE_EN
      logic          release_q;
`endif

      assign pressed = ~key_sync_q[1];
      assign cnt_inc = cnt_q + CNT_ONE;

      // Outputs are updated in the same edge as the state, so key_level and
      // the pulses appear in the cycle right after the deciding tick.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          key_sync_q <= 2'b11;
          state_q    <= IDLE;
          cnt_q      <= '0;
          level_q    <= 1'b0;
          press_q    <= 1'b0;
`ifdef KEY_RELEASE_PULSE_EN
          release_q  <= 1'b0;
`endif
        end else begin
          key_sync_q <= {key_sync_q[0], key_in[gi]};
          press_q    <= 1'b0;
`ifdef KEY_RELEASE_PULSE_EN
          release_q  <= 1'b0;
`endif
          if (tick) begin
            case (state_q)
              IDLE: begin
                if (pressed) begin
                  state_q <= PRESS_WAIT;
                  cnt_q   <= CNT_ONE;
                end
              end
              PRESS_WAIT: begin
                if (pressed) begin
                  // Compare before storing so the counter never wraps.
                  if (cnt_inc == CNT_MAX) begin
                    state_q <= HELD;
                    cnt_q   <= '0;
                    level_q <= 1'b1;
                    press_q <= 1'b1;
                  end else begin
                    cnt_q <= cnt_inc;
                  end
                end else begin
                  state_q <= IDLE;
                  cnt_q   <= '0;
                end
              end
              HELD: begin
                if (!pressed) begin
                  state_q <= REL_WAIT;
                  cnt_q   <= CNT_ONE;
                end
              end
              REL_WAIT: begin
                if (!pressed) begin
                  if (cnt_inc == CNT_MAX) begin
                    state_q   <= IDLE;
                    cnt_q     <= '0;
                    level_q   <= 1'b0;
`ifdef KEY_RELEASE_PULSE_EN
                    release_q <= 1'b1;
`endif
                  end else begin
                    cnt_q <= cnt_inc;
                  end
                end else begin
                  state_q <= HELD;
                  cnt_q   <= '0;
                end
              end
              default: begin
                state_q <= IDLE;
                cnt_q   <= '0;
                level_q <= 1'b0;
              end
            endcase
          end
        end
      end

      assign key_level[gi] = level_q;
      assign key_press[gi] = press_q;
`ifdef KEY_RELEASE_PULSE_EN
      assign key_release[gi] = release_q;
`endif
    end
  endgenerate

endmodule

// File: tb/tb_key_debounce.sv
module tb_key_debounce;

  localparam int KEYS = 4;
  localparam int ST   = 4;

  logic            clk       = 1'b0;
  logic            rst       = 1'b1;
  logic            clk_delay = 1'b0;
  logic [KEYS-1:0] key_in    = '1;
  logic            tick;
  logic [KEYS-1:0] key_level;
  logic [KEYS-1:0] key_press;
`ifdef KEY_RELEASE_PULSE_EN
  logic [KEYS-1:0] key_release;
`endif

  key_debounce #(
    .KEYS        (KEYS),
    .STABLE_TICKS(ST)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .clk_delay  (clk_delay),
    .key_in     (key_in),
    .tick       (tick),
    .key_level  (key_level),
    .key_press  (key_press)
`ifdef KEY_RELEASE_PULSE_EN
    ,
    .key_release(key_release)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [KEYS-1:0] press;
    logic [KEYS-1:0] level;
    logic [KEYS-1:0] rel;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks   = 0;
  int   n_pass     = 0;
  int   tick_count = 0;

  // Reference model: each key keeps its accepted level and the length of the
  // current run of samples that disagree with it.
  logic m_lvl[KEYS];
  int   m_run[KEYS];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
  endtask

  task automatic model_reset();
    for (int k = 0; k < KEYS; k++) begin
      m_lvl[k] = 1'b0;
      m_run[k] = 0;
    end
  endtask

  task automatic model_tick(input logic [KEYS-1:0] keys);
    exp_t e;
    logic p;
    e = '0;
    for (int k = 0; k < KEYS; k++) begin
      p = ~keys[k];
      if (p != m_lvl[k]) begin
        m_run[k]++;
        if (m_run[k] == ST) begin
          m_lvl[k] = p;
          m_run[k] = 0;
          if (p) e.press[k] = 1'b1;
          else   e.rel[k]   = 1'b1;
        end
      end else begin
        m_run[k] = 0;
      end
      e.level[k] = m_lvl[k];
    end
    exp_q.push_back(e);
  endtask

  // One clk_delay period (16 clk, toggling every 8) with keys held stable;
  // keys change together with the rising edge so both see the same
  // synchronizer latency and the tick samples exactly these values.
  task automatic period(input logic [KEYS-1:0] keys);
    @(negedge clk);
    key_in    = keys;
    clk_delay = 1'b1;
    model_tick(keys);
    repeat (8) @(negedge clk);
    clk_delay = 1'b0;
    repeat (7) @(negedge clk);
  endtask

  task automatic periods(input int n, input logic [KEYS-1:0] keys);
    for (int i = 0; i < n; i++) period(keys);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  // Monitor: every tick makes the following cycle the output cycle, where
  // the next expectation is popped and compared; all other cycles must show
  // no pulses and an unchanged level.
  logic            mon_post     = 1'b0;
  logic            mon_tick_d   = 1'b0;
  logic [KEYS-1:0] mon_lvl_exp  = '0;
  exp_t            mon_e;

  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        mon_lvl_exp = '0;
        mon_post    = 1'b0;
        check("rst_tick", 32'(tick), 32'd0);
        check("rst_press", 32'(key_press), 32'd0);
        check("rst_level", 32'(key_level), 32'd0);
`ifdef KEY_RELEASE_PULSE_EN
        check("rst_release", 32'(key_release), 32'd0);
`endif
      end else if (mon_post) begin
        mon_post = 1'b0;
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL exp_queue: got 0 entries, expected at least 1 at %0t", $time);
        end else begin
          mon_e = exp_q.pop_front();
          mon_lvl_exp = mon_e.level;
          check("press", 32'(key_press), 32'(mon_e.press));
          check("level", 32'(key_level), 32'(mon_e.level));
`ifdef KEY_RELEASE_PULSE_EN
          check("release", 32'(key_release), 32'(mon_e.rel));
`endif
        end
      end else begin
        check("idle_press", 32'(key_press), 32'd0);
        check("idle_level", 32'(key_level), 32'(mon_lvl_exp));
`ifdef KEY_RELEASE_PULSE_EN
        check("idle_release", 32'(key_release), 32'd0);
`endif
      end
      if (!rst && tick) begin
        tick_count++;
        check("tick_width", 32'(mon_tick_d), 32'd0);
        mon_post = 1'b1;
      end
      mon_tick_d = tick;
    end
  end

  int              t0;
  logic [KEYS-1:0] cur;

  initial begin
    model_reset();
    rst       = 1'b1;
    key_in    = '1;
    clk_delay = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    periods(2, 4'b1111);

    // Bounce on key 0: low, high, then low for ST ticks.
    period(4'b1110);
    period(4'b1111);
    periods(ST, 4'b1110);

    // Short glitch on key 1 while key 0 stays held.
    periods(ST - 1, 4'b1100);
    periods(2, 4'b1110);

    // Release key 0.
    periods(ST + 1, 4'b1111);

    // All keys pressed together, then released together.
    periods(ST, 4'b0000);
    periods(ST + 1, 4'b1111);

    // Reset in the middle of debouncing key 2, key stays held.
    periods(2, 4'b1011);
    do_reset();
    periods(ST, 4'b1011);
    periods(ST + 1, 4'b1111);

    // clk_delay stalled: key activity must not change anything.
    @(negedge clk);
    key_in = 4'b0000;
    repeat (40) @(negedge clk);
    key_in = 4'b0101;
    repeat (40) @(negedge clk);
    key_in = 4'b1111;
    repeat (4) @(negedge clk);

    // Tick count over 10 clk_delay periods.
    t0 = tick_count;
    periods(10, 4'b1111);
    check("tick_count_10", 32'(tick_count - t0), 32'd10);

    // Randomized key activity, each key flipping with probability 1/4.
    cur = '1;
    for (int i = 0; i < 80; i++) begin
      for (int k = 0; k < KEYS; k++)
        if ($urandom_range(3) == 0) cur[k] = ~cur[k];
      period(cur);
    end

    repeat (5) @(negedge clk);
    check("exp_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
